// File: rtl/direction_controller.sv
// Direction controller: debounced button toggles, bounce-mode limit reversal.
// Latency: button to btn_level is 2 + DEBOUNCE_CYCLES edges; toggle one edge later; dir_change one edge after that.
// Backpressure: none; count and mode are sampled every cycle, and the counter follows up_down unconditionally.
module direction_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             mode,
  input  logic [CNT_W-1:0] count,
  output logic             up_down,
  output logic             dir_change,
  output logic             btn_level
);

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } state_e;

  // Reversal limits: turning at max-1 or at 1 lets the counter take one more
  // step in the old direction, so it peaks at max and bottoms at zero.
  localparam logic [CNT_W-1:0] HI_LIMIT  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] LO_LIMIT  = CNT_W'(1);
  localparam logic [7:0]       STAB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic [7:0] stab_cnt_q, stab_cnt_d;
  logic       btn_level_q, btn_level_d;
  logic       btn_prev_q;
  logic       press;
  logic       at_hi, at_lo;
  state_e     state_q, state_d;
  state_e     state_prev_q;
  logic       dir_change_q, dir_change_d;

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive samples that differ from the current level;
  // any agreeing sample restarts the count from zero.
  always_comb begin
    stab_cnt_d  = '0;
    btn_level_d = btn_level_q;
    if (sync2_q != btn_level_q) begin
      if (stab_cnt_q == STAB_LAST) begin
        btn_level_d = sync2_q;
      end else begin
        stab_cnt_d = stab_cnt_q + 8'd1;
      end
    end
  end

  // Debounce state and the previous level used for press edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt_q  <= '0;
      btn_level_q <= 1'b0;
      btn_prev_q  <= 1'b0;
    end else begin
      stab_cnt_q  <= stab_cnt_d;
      btn_level_q <= btn_level_d;
      btn_prev_q  <= btn_level_q;
    end
  end

  assign press = btn_level_q & ~btn_prev_q;
  assign at_hi = (count >= HI_LIMIT);
  assign at_lo = (count <= LO_LIMIT);

  // Next direction: a bounce-mode limit reversal takes priority and swallows
  // a coincident press, so the state flips exactly once.
  always_comb begin
    state_d = state_q;
    if (state_q == UP) begin
      if (mode && at_hi) begin
        state_d = DOWN;
      end else if (press) begin
        state_d = DOWN;
      end
    end else begin
      if (mode && at_lo) begin
        state_d = UP;
      end else if (press) begin
        state_d = UP;
      end
    end
  end

  // Pulse one cycle after the direction register has changed.
  always_comb begin
    dir_change_d = (state_q != state_prev_q);
  end

  // Direction state, its one-cycle history and the change pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UP;
      state_prev_q <= UP;
      dir_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      state_prev_q <= state_q;
      dir_change_q <= dir_change_d;
    end
  end

  assign up_down    = (state_q == UP);
  assign dir_change = dir_change_q;
  assign btn_level  = btn_level_q;

endmodule

// File: doc/direction_controller.md
DIRECTION_CONTROLLER -- requirements
Module: direction_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples that qualify a button level; legal range is 2..255.
REQ-002 Parameter CNT_W, default 4, is the width of the monitored counter value.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is the reset: asynchronous, active-high.
REQ-005 btn  input  1  is the raw, asynchronous direction-toggle pushbutton (1 = pressed).
REQ-006 mode  input  1  selects the mode: 0 = manual (button only), 1 = bounce (automatic reversal at the limits, plus the button).
REQ-007 count  input  CNT_W  is the current value of the downstream up/down counter.
REQ-008 up_down  output  1  is the registered direction to the counter: 1 = up, 0 = down.
REQ-009 dir_change  output  1  is a registered one-cycle pulse, high in the cycle after any up_down transition.
REQ-010 btn_level  output  1  is the registered, debounced button level.

Function
REQ-011 btn shall pass through a 2-flop synchronizer before any other use.
REQ-012 btn_level shall take the synchronized value only after that value has differed from btn_level on DEBOUNCE_CYCLES consecutive clock edges.
REQ-013 Any sample equal to the current btn_level shall restart the stability count.
REQ-014 A press event shall be a 0->1 transition of btn_level, one cycle wide.
REQ-015 Total latency from a clean btn rise to btn_level = 1 shall be 2 + DEBOUNCE_CYCLES edges; release shall have the same latency and shall generate no event.
REQ-016 The direction FSM shall have two states: UP (up_down = 1) and DOWN (up_down = 0).
REQ-017 In either mode, a press event shall toggle the state at the next edge.
REQ-018 In bounce mode, state UP with count >= 2^CNT_W-2 (14 for CNT_W = 4) shall go to DOWN at the next edge, so the counter peaks at 15 and never wraps.
REQ-019 In bounce mode, state DOWN with count <= 1 shall go to UP at the next edge, so the counter bottoms at 0 and never wraps.
REQ-020 The >=/<= comparisons in REQ-018 and REQ-019 shall also cover mode switching to 1 while count is already at or past a limit: reversal occurs on the first edge with mode = 1.
REQ-021 When a press event and a bounce-mode limit reversal coincide, the limit reversal shall win, the press shall be discarded, and the state changes exactly once.
REQ-022 In bounce mode, a press at a non-limit count shall toggle normally; a subsequent limit shall still reverse.
REQ-023 In manual mode, the limits shall be ignored and the counter wraps freely.
REQ-024 dir_change shall be 1 in exactly the cycle following each up_down change and 0 otherwise; it shall never be high two consecutive cycles from one event.
REQ-025 mode and count are synchronous to clk and shall be sampled without synchronizers.

Reset
REQ-026 While rst = 1, independent of clk: up_down = 1, dir_change = 0, btn_level = 0, synchronizer flops = 0, stability counter = 0.
REQ-027 A btn held high through reset release shall be debounced afresh, producing one press event 2 + DEBOUNCE_CYCLES edges after release.
REQ-028 Reset asserted mid-debounce or mid-reversal shall abort the operation with no residual pulse after release.

Verification
REQ-029 Bench: rst high 10 ns then low, mode = 0, btn = 0, count = 0 -> up_down = 1, dir_change = 0, btn_level = 0 throughout.
REQ-030 Bench: mode = 0, btn high 1 cycle only (glitch), DEBOUNCE_CYCLES = 4 -> btn_level stays 0, no up_down change.
REQ-031 Bench: mode = 0, btn held 10 cycles -> btn_level = 1 at edge 6, up_down 1->0 at edge 7, dir_change = 1 at edge 8 only; release produces no toggle.
REQ-032 Bench: mode = 1, counter model driven by up_down from 0 -> count sequence 0..15,14..0,1..., never 15->0 or 0->15; dir_change pulses once per turn.
REQ-033 Bench: mode = 1, UP, count = 14, press event same cycle -> single toggle to DOWN, next counter value 14 after 15.
REQ-034 Bench: mode = 0 holding count = 15 in UP, then mode -> 1 -> up_down = 0 on the first edge with mode = 1; async rst mid-sequence returns up_down = 1 immediately.
